renode_axi_manager: RTL

Renode-side AXI4-Lite manager. It is the initiator counterpart of the Renode memory subordinate. A simple request/response channel, fed by the Renode connection, carries Byte/Word/DoubleWord/QuadWord accesses. The block converts each request into a single AXI4-Lite read or write on a 64-bit data bus, then returns the data and an error flag.

---
 rtl/renode_axi_manager_if.sv | 51 +++++
 rtl/renode_axi_manager.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/renode_axi_manager_if.sv
// Request/response channel plus AXI4-Lite manager signals for renode_axi_manager.
// The master modport is the manager's own view; slave is the Renode/subordinate side.
interface renode_axi_manager_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [1:0]            req_size_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [63:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [63:0]           rsp_rdata_o;
  logic                  rsp_error_o;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr_o;
  logic                  m_axi_awvalid_o;
  logic                  m_axi_awready_i;
  logic [63:0]           m_axi_wdata_o;
  logic [7:0]            m_axi_wstrb_o;
  logic                  m_axi_wvalid_o;
  logic                  m_axi_wready_i;
  logic [1:0]            m_axi_bresp_i;
  logic                  m_axi_bvalid_i;
  logic                  m_axi_bready_o;
  logic [ADDR_WIDTH-1:0] m_axi_araddr_o;
  logic                  m_axi_arvalid_o;
  logic                  m_axi_arready_i;
  logic [63:0]           m_axi_rdata_i;
  logic [1:0]            m_axi_rresp_i;
  logic                  m_axi_rvalid_i;
  logic                  m_axi_rready_o;

  modport master (
    input  req_valid_i, req_write_i, req_size_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  m_axi_awready_i, m_axi_wready_i, m_axi_bresp_i, m_axi_bvalid_i,
    input  m_axi_arready_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rvalid_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
    output m_axi_awaddr_o, m_axi_awvalid_o, m_axi_wdata_o, m_axi_wstrb_o, m_axi_wvalid_o,
    output m_axi_bready_o, m_axi_araddr_o, m_axi_arvalid_o, m_axi_rready_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_size_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output m_axi_awready_i, m_axi_wready_i, m_axi_bresp_i, m_axi_bvalid_i,
    output m_axi_arready_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rvalid_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
    input  m_axi_awaddr_o, m_axi_awvalid_o, m_axi_wdata_o, m_axi_wstrb_o, m_axi_wvalid_o,
    input  m_axi_bready_o, m_axi_araddr_o, m_axi_arvalid_o, m_axi_rready_o
  );
endinterface

// File: rtl/renode_axi_manager.sv
// Renode-side AXI4-Lite manager: turns one Byte/Word/DoubleWord/QuadWord request into a
// single AXI4-Lite read or write on a 64-bit bus and returns right-aligned data plus error.
module renode_axi_manager #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  renode_axi_manager_if.master bus_io
);
  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("renode_axi_manager: DATA_WIDTH must be 64");
  end

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWr     = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRd     = 3'd3;
  localparam logic [2:0] StRdResp = 3'd4;
  localparam logic [2:0] StResp   = 3'd5;

  logic [2:0]            r_state;
  logic                  r_req_ready, r_rsp_valid, r_rsp_error;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [63:0]           r_wdata, r_rsp_rdata, r_rmask;
  logic [7:0]            r_wstrb;
  logic [2:0]            r_off;

  logic [2:0]  w_off;
  logic [7:0]  w_bmask;
  logic [63:0] w_dmask, w_rdata;
  logic        w_misaligned, w_accept, w_aw_done, w_w_done, w_unused;

  always_comb begin
    w_off        = bus_io.req_addr_i[2:0];
    w_bmask      = 8'hFF;
    w_misaligned = 1'b0;
    case (bus_io.req_size_i)
      2'd0:    w_bmask = 8'h01;
      2'd1:    begin w_bmask = 8'h03; w_misaligned = w_off[0];     end
      2'd2:    begin w_bmask = 8'h0F; w_misaligned = |w_off[1:0];  end
      default: begin w_bmask = 8'hFF; w_misaligned = |w_off;       end
    endcase
    w_dmask = '0;
    for (int i = 0; i < 8; i++) w_dmask[8*i +: 8] = {8{w_bmask[i]}};
  end

  // r_req_ready is only ever high in StIdle, so it doubles as the IDLE qualifier.
  assign w_accept  = r_req_ready & bus_io.req_valid_i;
  assign w_aw_done = !r_awvalid || bus_io.m_axi_awready_i;
  assign w_w_done  = !r_wvalid || bus_io.m_axi_wready_i;
  assign w_rdata   = (bus_io.m_axi_rdata_i >> {r_off, 3'b000}) & r_rmask;
  assign w_unused  = ^{bus_io.m_axi_bresp_i[0], bus_io.m_axi_rresp_i[0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_off       <= '0;
      r_rmask     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_off       <= w_off;
            r_rmask     <= w_dmask;
            if (w_misaligned) begin
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= StResp;
            end else if (bus_io.req_write_i) begin
              r_awaddr  <= bus_io.req_addr_i;
              r_wdata   <= (bus_io.req_wdata_i & w_dmask) << {w_off, 3'b000};
              r_wstrb   <= w_bmask << w_off;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= StWr;
            end else begin
              r_araddr  <= bus_io.req_addr_i;
              r_arvalid <= 1'b1;
              r_state   <= StRd;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        StWr: begin
          if (bus_io.m_axi_awready_i) r_awvalid <= 1'b0;
          if (bus_io.m_axi_wready_i)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= StWrResp;
          end
        end
        StWrResp: begin
          if (bus_io.m_axi_bvalid_i) begin
            r_bready    <= 1'b0;
            r_rsp_error <= bus_io.m_axi_bresp_i[1];
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StRd: begin
          if (bus_io.m_axi_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdResp;
          end
        end
        StRdResp: begin
          if (bus_io.m_axi_rvalid_i) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= w_rdata;
            r_rsp_error <= bus_io.m_axi_rresp_i[1];
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (bus_io.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus_io.req_ready_o     = r_req_ready;
  assign bus_io.rsp_valid_o     = r_rsp_valid;
  assign bus_io.rsp_rdata_o     = r_rsp_rdata;
  assign bus_io.rsp_error_o     = r_rsp_error;
  assign bus_io.m_axi_awaddr_o  = r_awaddr;
  assign bus_io.m_axi_awvalid_o = r_awvalid;
  assign bus_io.m_axi_wdata_o   = r_wdata;
  assign bus_io.m_axi_wstrb_o   = r_wstrb;
  assign bus_io.m_axi_wvalid_o  = r_wvalid;
  assign bus_io.m_axi_bready_o  = r_bready;
  assign bus_io.m_axi_araddr_o  = r_araddr;
  assign bus_io.m_axi_arvalid_o = r_arvalid;
  assign bus_io.m_axi_rready_o  = r_rready;
endmodule
